msg_scroller: RTL and testbench

Parametrised message sequencer for the seven-segment display path. It holds a writable nibble message, by default DEPTH=16 hex digits, and steps a read pointer through it at a programmable rate or on manual steps. It presents a window of NDIG consecutive digits for the display multiplexer. It replaces the fixed index-to-digit lookup: message contents, length, direction and step rate are now runtime or build-time controls.

---
 rtl/msg_scroller.sv | 142 ++++++++++++++
 tb/tb_msg_scroller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroller.sv
// Seven-segment message sequencer: a writable nibble message, a read pointer
// that steps on a prescaled tick or on manual request, and an NDIG-digit window.
module msg_scroller #(
    parameter int             DW   = 4,
    parameter int             AW   = 4,
    parameter int             NDIG = 4,
    parameter int             DIV  = 50_000_000,
    parameter logic [DW-1:0]  FILL = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [AW-1:0]        last,
    input  logic                 run,
    input  logic                 dir,
    input  logic                 step,
    input  logic                 clear,
    output logic [AW-1:0]        pos,
    output logic [NDIG*DW-1:0]   digits,
    output logic                 wrap
);

    localparam int             DEPTH   = 2**AW;
    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_pos;
    logic          r_wrap;

    logic [PW-1:0] w_presc_nxt;
    logic [AW-1:0] w_pos_nxt;
    logic          w_wrap_nxt;
    logic          w_tick;
    logic          w_adv;

    // Message storage; writes are honoured regardless of clear or advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= FILL;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Prescaler, pointer and wrap pulse state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_pos   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_pos   <= w_pos_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Step decision: manual steps only count while paused.
    always_comb begin
        w_tick = run && (r_presc == PRE_MAX);
        if (run) begin
            w_adv = w_tick;
        end else begin
            w_adv = step;
        end
    end

    // Prescaler next value: frozen while paused, restarted by clear.
    always_comb begin
        w_presc_nxt = r_presc;
        if (clear) begin
            w_presc_nxt = '0;
        end else if (run) begin
            if (w_tick) begin
                w_presc_nxt = '0;
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end else begin
            w_presc_nxt = r_presc;
        end
    end

    // Pointer next value; an out-of-range pointer reloads without a wrap pulse.
    always_comb begin
        w_pos_nxt  = r_pos;
        w_wrap_nxt = 1'b0;
        if (clear) begin
            w_pos_nxt  = '0;
            w_wrap_nxt = 1'b0;
        end else if (w_adv) begin
            if (!dir) begin
                if (r_pos >= last) begin
                    w_pos_nxt  = '0;
                    w_wrap_nxt = (r_pos == last);
                end else begin
                    w_pos_nxt  = r_pos + AW'(1);
                    w_wrap_nxt = 1'b0;
                end
            end else begin
                if (r_pos == '0) begin
                    w_pos_nxt  = last;
                    w_wrap_nxt = 1'b1;
                end else if (r_pos > last) begin
                    w_pos_nxt  = last;
                    w_wrap_nxt = 1'b0;
                end else begin
                    w_pos_nxt  = r_pos - AW'(1);
                    w_wrap_nxt = 1'b0;
                end
            end
        end else begin
            w_pos_nxt  = r_pos;
            w_wrap_nxt = 1'b0;
        end
    end

    // Window walk: each following digit wraps back to 0 after the final digit.
    always_comb begin
        logic [AW-1:0] w_idx;
        digits = '0;
        w_idx  = r_pos;
        for (int k = 0; k < NDIG; k++) begin
            digits[(NDIG-1-k)*DW +: DW] = r_mem[w_idx];
            if (w_idx >= last) begin
                w_idx = '0;
            end else begin
                w_idx = w_idx + AW'(1);
            end
        end
    end

    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_msg_scroller.sv
// Scoreboard bench for msg_scroller: a driver updates a behavioural model and
// queues expectations; a monitor compares DUT outputs after every clock edge.
module tb_msg_scroller;

    localparam int            DW    = 4;
    localparam int            AW    = 4;
    localparam int            NDIG  = 4;
    localparam int            DIV   = 4;
    localparam int            DEPTH = 16;
    localparam int            EW    = AW + 1 + NDIG*DW;
    localparam logic [DW-1:0] FILL  = 4'hA;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                we = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [DW-1:0]       wdata = '0;
    logic [AW-1:0]       last = '0;
    logic                run = 1'b0;
    logic                dir = 1'b0;
    logic                step = 1'b0;
    logic                clear = 1'b0;
    logic [AW-1:0]       pos;
    logic [NDIG*DW-1:0]  digits;
    logic                wrap;

    int vectors     = 0;
    int miscompares = 0;

    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] mon_e;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_pos;
    int            m_runs;

    msg_scroller #(
        .DW(DW), .AW(AW), .NDIG(NDIG), .DIV(DIV), .FILL(FILL)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .last(last), .run(run), .dir(dir), .step(step), .clear(clear),
        .pos(pos), .digits(digits), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NDIG*DW-1:0] m_window(input int lst);
        logic [NDIG*DW-1:0] win;
        int idx;
        idx = m_pos;
        for (int k = 0; k < NDIG; k++) begin
            win[(NDIG-1-k)*DW +: DW] = m_mem[idx];
            idx = (idx >= lst) ? 0 : idx + 1;
        end
        return win;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
        m_pos  = 0;
        m_runs = 0;
    endtask

    // One clock of stimulus; the model yields the state expected after the edge.
    task automatic cyc(input logic i_we, input logic [3:0] i_wa, input logic [3:0] i_wd,
                       input logic i_run, input logic i_dir, input logic i_step,
                       input logic i_clear, input logic [3:0] i_last);
        bit adv;
        bit mwrap;
        int lst;
        @(negedge clk);
        we = i_we; waddr = i_wa; wdata = i_wd; run = i_run; dir = i_dir;
        step = i_step; clear = i_clear; last = i_last;
        lst   = int'(i_last);
        adv   = 1'b0;
        mwrap = 1'b0;
        if (i_clear) begin
            m_runs = 0;
            m_pos  = 0;
        end else begin
            if (i_run) begin
                m_runs++;
                adv = ((m_runs % DIV) == 0);
            end else begin
                adv = i_step;
            end
            if (adv) begin
                if (!i_dir) begin
                    if (m_pos >= lst) begin
                        mwrap = (m_pos == lst);
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    if (m_pos == 0) begin
                        m_pos = lst;
                        mwrap = 1'b1;
                    end else if (m_pos > lst) begin
                        m_pos = lst;
                    end else begin
                        m_pos--;
                    end
                end
            end
        end
        if (i_we) m_mem[i_wa] = i_wd;
        exp_q.push_back({4'(m_pos), mwrap, m_window(lst)});
    endtask

    task automatic check_reset_now();
        logic [NDIG*DW-1:0] fill_win;
        fill_win = {NDIG{FILL}};
        chk("reset_pos", 16'(pos), 16'h0000);
        chk("reset_wrap", 16'(wrap), 16'h0000);
        chk("reset_digits", 16'(digits), 16'(fill_win));
    endtask

    // Asynchronous reset between edges, checked before any further clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_now();
        we = 1'b0; step = 1'b0; clear = 1'b0; run = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("pos", 16'(pos), 16'(mon_e[EW-1 -: AW]));
                chk("wrap", 16'(wrap), 16'(mon_e[NDIG*DW]));
                chk("digits", 16'(digits), 16'(mon_e[NDIG*DW-1:0]));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        logic r_run, r_dir, r_we, r_step, r_clr;
        logic [3:0] r_last;
        model_reset();
        #2;
        rst = 1'b1;
        #10;
        check_reset_now();
        @(negedge clk);
        rst = 1'b0;

        // Load message with value = address, then three manual steps
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
            cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
        end
        // Wrap up with last=7, then walk to pos 6
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
            cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        // Down wrap from 0, then out-of-range reload
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        // Auto stepping, a 3-cycle pause, and ignored steps while running
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'(i % 2), 1'b0, 4'd15);
        // Clear landing on a tick while pos == last
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        for (int i = 0; i < 9; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        // Reset mid-count, then step the fill pattern through every position
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);

        // Randomized traffic
        r_run = 1'b0; r_dir = 1'b0; r_last = 4'd15;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7, 0) == 0) r_run = ~r_run;
            if ($urandom_range(15, 0) == 0) r_dir = ~r_dir;
            if ($urandom_range(19, 0) == 0) r_last = 4'($urandom_range(15, 0));
            r_we   = ($urandom_range(2, 0) == 0);
            r_step = ($urandom_range(3, 0) == 0);
            r_clr  = ($urandom_range(39, 0) == 0);
            cyc(r_we, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                r_run, r_dir, r_step, r_clr, r_last);
            if (i == 700) do_reset();
        end

        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, r_last);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
